// File: rtl/rggen_apb_register_adapter.sv
// APB slave bridge that broadcasts one access to the generated registers and merges their
// replies. Adds address pre-decode, a BUSY-cycle timeout and error mapping.
module rggen_apb_register_adapter #(
  parameter int unsigned                ADDRESS_WIDTH       = 8,
  parameter int unsigned                LOCAL_ADDRESS_WIDTH = 8,
  parameter int unsigned                BUS_WIDTH           = 32,
  parameter int unsigned                REGISTERS           = 1,
  parameter bit                         PRE_DECODE          = 1'b0,
  parameter logic [ADDRESS_WIDTH-1:0]   BASE_ADDRESS        = '0,
  parameter bit                         ERROR_STATUS        = 1'b0,
  parameter logic [BUS_WIDTH-1:0]       DEFAULT_READ_DATA   = '0,
  parameter int unsigned                TIMEOUT_CYCLES      = 0
) (
  input  logic                              i_clk,
  input  logic                              i_rst_n,
  input  logic                              i_psel,
  input  logic                              i_penable,
  input  logic                              i_pwrite,
  input  logic [ADDRESS_WIDTH-1:0]          i_paddr,
  input  logic [2:0]                        i_pprot,
  input  logic [BUS_WIDTH-1:0]              i_pwdata,
  input  logic [BUS_WIDTH/8-1:0]            i_pstrb,
  output logic                              o_pready,
  output logic                              o_pslverr,
  output logic [BUS_WIDTH-1:0]              o_prdata,
  output logic                              o_access_valid,
  output logic                              o_access_write,
  output logic [LOCAL_ADDRESS_WIDTH-1:0]    o_access_address,
  output logic [BUS_WIDTH-1:0]              o_access_data,
  output logic [BUS_WIDTH-1:0]              o_access_strobe,
  input  logic [REGISTERS-1:0]              i_register_active,
  input  logic [REGISTERS-1:0]              i_register_ready,
  input  logic [2*REGISTERS-1:0]            i_register_status,
  input  logic [BUS_WIDTH*REGISTERS-1:0]    i_register_value
);

  localparam int unsigned COUNT_WIDTH = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  // One extra bit so BASE + window size cannot wrap at the top of the address space.
  localparam logic [ADDRESS_WIDTH:0] RANGE_LO = {1'b0, BASE_ADDRESS};
  localparam logic [ADDRESS_WIDTH:0] RANGE_HI =
    RANGE_LO + (ADDRESS_WIDTH+1)'((64'd1 << LOCAL_ADDRESS_WIDTH) - 64'd1);

  typedef enum logic [1:0] {IDLE, BUSY, RESPOND} state_e;

  state_e                         state;
  state_e                         state_next;
  logic                           setup;
  logic                           in_range;
  logic                           reject;
  logic                           hit;
  logic                           ready;
  logic                           timeout;
  logic [BUS_WIDTH-1:0]           hit_value;
  logic [1:0]                     hit_status;
  logic [BUS_WIDTH-1:0]           strobe_expand;
  logic [BUS_WIDTH-1:0]           resp_data;
  logic                           resp_error;
  logic                           resp_write;
  logic                           write_q;
  logic [LOCAL_ADDRESS_WIDTH-1:0] address_q;
  logic [BUS_WIDTH-1:0]           data_q;
  logic [BUS_WIDTH-1:0]           strobe_q;
  logic [BUS_WIDTH-1:0]           rdata_q;
  logic                           slverr_q;
  logic [COUNT_WIDTH-1:0]         busy_count;
  logic                           unused_inputs;

  assign unused_inputs = ^{i_pprot, hit_status[0]};

  assign setup    = i_psel && !i_penable;
  assign in_range = ({1'b0, i_paddr} >= RANGE_LO) && ({1'b0, i_paddr} <= RANGE_HI);
  assign reject   = PRE_DECODE && !in_range;
  assign hit      = |i_register_active;
  assign ready    = |(i_register_active & i_register_ready);
  assign timeout  = (TIMEOUT_CYCLES != 0) &&
                    (busy_count == COUNT_WIDTH'(TIMEOUT_CYCLES - 1));

  always_comb begin
    hit_value  = '0;
    hit_status = '0;
    for (int unsigned i = 0; i < REGISTERS; i++) begin
      if (i_register_active[i]) begin
        hit_value  = hit_value  | i_register_value[i*BUS_WIDTH +: BUS_WIDTH];
        hit_status = hit_status | i_register_status[2*i +: 2];
      end
    end
  end

  always_comb begin
    strobe_expand = '0;
    for (int unsigned i = 0; i < BUS_WIDTH/8; i++) begin
      strobe_expand[8*i +: 8] = {8{i_pstrb[i]}};
    end
  end

  // Pre-decode rejects respond straight from IDLE, before write_q has been latched.
  always_comb begin
    resp_write = (state == IDLE) ? i_pwrite : write_q;
    resp_data  = DEFAULT_READ_DATA;
    resp_error = ERROR_STATUS;
    if (state == BUSY && hit && ready) begin
      resp_data  = hit_value;
      resp_error = hit_status[1];
    end
    if (resp_write) begin
      resp_data = '0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (setup) begin
          state_next = reject ? RESPOND : BUSY;
        end
      end
      BUSY: begin
        if (!i_psel) begin
          state_next = IDLE;
        end else if (!hit || ready || timeout) begin
          state_next = RESPOND;
        end
      end
      RESPOND: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_pready         = (state == RESPOND);
    o_pslverr        = (state == RESPOND) ? slverr_q : 1'b0;
    o_prdata         = (state == RESPOND) ? rdata_q : '0;
    o_access_valid   = (state == BUSY);
    o_access_write   = write_q;
    o_access_address = address_q;
    o_access_data    = data_q;
    o_access_strobe  = strobe_q;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      write_q    <= 1'b0;
      address_q  <= '0;
      data_q     <= '0;
      strobe_q   <= '0;
      rdata_q    <= '0;
      slverr_q   <= 1'b0;
      busy_count <= '0;
    end else begin
      if (state == IDLE && setup) begin
        write_q   <= i_pwrite;
        address_q <= i_paddr[LOCAL_ADDRESS_WIDTH-1:0];
        data_q    <= i_pwdata;
        strobe_q  <= i_pwrite ? strobe_expand : '1;
      end
      if (state_next == RESPOND && state != RESPOND) begin
        rdata_q  <= resp_data;
        slverr_q <= resp_error;
      end
      if (state == BUSY && state_next == BUSY) begin
        busy_count <= busy_count + 1'b1;
      end else begin
        busy_count <= '0;
      end
    end
  end

endmodule

// File: tb/tb_rggen_apb_register_adapter.sv
// Directed bench for rggen_apb_register_adapter: two configurations share one APB master,
// each with its own register-side stimulus.
module tb_rggen_apb_register_adapter;

  logic        clk;
  logic        rst_n;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [7:0]  paddr;
  logic [2:0]  pprot;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;

  logic        a_pready, a_pslverr, a_valid, a_write;
  logic [31:0] a_prdata, a_data, a_strobe;
  logic [7:0]  a_addr;
  logic [1:0]  a_active, a_ready;
  logic [3:0]  a_status;
  logic [63:0] a_value;

  logic        b_pready, b_pslverr, b_valid, b_write;
  logic [31:0] b_prdata, b_data, b_strobe;
  logic [3:0]  b_addr;
  logic [1:0]  b_active, b_ready;
  logic [3:0]  b_status;
  logic [63:0] b_value;

  int total = 0;
  int bad   = 0;

  rggen_apb_register_adapter #(
    .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(8), .BUS_WIDTH(32), .REGISTERS(2),
    .PRE_DECODE(1'b0), .BASE_ADDRESS(8'h00), .ERROR_STATUS(1'b0),
    .DEFAULT_READ_DATA(32'hFFFF_0000), .TIMEOUT_CYCLES(0)
  ) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pprot(pprot), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(a_pready), .o_pslverr(a_pslverr), .o_prdata(a_prdata),
    .o_access_valid(a_valid), .o_access_write(a_write), .o_access_address(a_addr),
    .o_access_data(a_data), .o_access_strobe(a_strobe),
    .i_register_active(a_active), .i_register_ready(a_ready),
    .i_register_status(a_status), .i_register_value(a_value)
  );

  rggen_apb_register_adapter #(
    .ADDRESS_WIDTH(8), .LOCAL_ADDRESS_WIDTH(4), .BUS_WIDTH(32), .REGISTERS(2),
    .PRE_DECODE(1'b1), .BASE_ADDRESS(8'h40), .ERROR_STATUS(1'b1),
    .DEFAULT_READ_DATA(32'hCAFE_F00D), .TIMEOUT_CYCLES(4)
  ) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_psel(psel), .i_penable(penable), .i_pwrite(pwrite),
    .i_paddr(paddr), .i_pprot(pprot), .i_pwdata(pwdata), .i_pstrb(pstrb),
    .o_pready(b_pready), .o_pslverr(b_pslverr), .o_prdata(b_prdata),
    .o_access_valid(b_valid), .o_access_write(b_write), .o_access_address(b_addr),
    .o_access_data(b_data), .o_access_strobe(b_strobe),
    .i_register_active(b_active), .i_register_ready(b_ready),
    .i_register_status(b_status), .i_register_value(b_value)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic setup_phase(input logic w, input logic [7:0] a, input logic [31:0] d,
                             input logic [3:0] s);
    psel    = 1'b1;
    penable = 1'b0;
    pwrite  = w;
    paddr   = a;
    pwdata  = d;
    pstrb   = s;
  endtask

  task automatic bus_idle();
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = '0;
    pprot = '0; pwdata = '0; pstrb = '0;
    a_active = '0; a_ready = '0; a_status = '0; a_value = '0;
    b_active = '0; b_ready = '0; b_status = '0; b_value = '0;
    step();
    step();
    chk("rst_pready", a_pready, 1'b0);
    chk("rst_pslverr", a_pslverr, 1'b0);
    chk("rst_prdata", a_prdata, 32'h0);
    chk("rst_valid", a_valid, 1'b0);
    chk("rst_write", a_write, 1'b0);
    chk("rst_addr", a_addr, 8'h00);
    chk("rst_data", a_data, 32'h0);
    chk("rst_strobe", a_strobe, 32'h0);
    chk("rst_b_pready", b_pready, 1'b0);
    rst_n = 1'b1;
    step();

    // write to register 1, ready in the first BUSY cycle
    a_active = 2'b10; a_ready = 2'b10; a_value = {32'h5555_5555, 32'h0};
    setup_phase(1'b1, 8'h04, 32'hDEAD_BEEF, 4'b0101);
    step();
    penable = 1'b1;
    chk("wr_valid", a_valid, 1'b1);
    chk("wr_write", a_write, 1'b1);
    chk("wr_addr", a_addr, 8'h04);
    chk("wr_data", a_data, 32'hDEAD_BEEF);
    chk("wr_strobe", a_strobe, 32'h00FF_00FF);
    chk("wr_t1_pready", a_pready, 1'b0);
    step();
    chk("wr_t2_pready", a_pready, 1'b1);
    chk("wr_pslverr", a_pslverr, 1'b0);
    chk("wr_prdata", a_prdata, 32'h0);
    chk("wr_valid_fall", a_valid, 1'b0);
    bus_idle(); a_active = '0; a_ready = '0;
    step();
    chk("wr_t3_pready", a_pready, 1'b0);
    chk("wr_t3_prdata", a_prdata, 32'h0);

    // read of register 0 that becomes ready in the third BUSY cycle; status 00 then 10
    for (int k = 0; k < 2; k++) begin
      a_value  = {32'hFFFF_FFFF, 32'h1234_5678};
      a_status = (k == 0) ? 4'b1100 : 4'b1110;
      a_active = 2'b01; a_ready = 2'b00;
      setup_phase(1'b0, 8'h08, 32'h0, 4'b0000);
      step();
      penable = 1'b1;
      chk("rd_valid", a_valid, 1'b1);
      chk("rd_write", a_write, 1'b0);
      chk("rd_strobe", a_strobe, 32'hFFFF_FFFF);
      step();
      chk("rd_t2_pready", a_pready, 1'b0);
      step();
      a_ready = 2'b01;
      chk("rd_t3_pready", a_pready, 1'b0);
      step();
      chk("rd_t4_pready", a_pready, 1'b1);
      chk("rd_prdata", a_prdata, 32'h1234_5678);
      chk("rd_pslverr", a_pslverr, (k == 0) ? 1'b0 : 1'b1);
      bus_idle(); a_active = '0; a_ready = '0; a_status = '0;
      step();
    end

    // no register decodes the address
    a_value = {32'h0000_0001, 32'h0000_0002};
    setup_phase(1'b0, 8'h10, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("nohit_valid", a_valid, 1'b1);
    step();
    chk("nohit_pready", a_pready, 1'b1);
    chk("nohit_pslverr", a_pslverr, 1'b0);
    chk("nohit_prdata", a_prdata, 32'hFFFF_0000);
    bus_idle();
    step();

    // pre-decode: one past the top of the window, then one below the base
    setup_phase(1'b0, 8'h50, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("pd_hi_valid", b_valid, 1'b0);
    chk("pd_hi_pready", b_pready, 1'b1);
    chk("pd_hi_pslverr", b_pslverr, 1'b1);
    chk("pd_hi_prdata", b_prdata, 32'hCAFE_F00D);
    step();
    chk("pd_hi_t2_valid", b_valid, 1'b0);
    chk("pd_hi_t2_pready", b_pready, 1'b0);
    bus_idle();
    step();
    step();
    setup_phase(1'b0, 8'h3F, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("pd_lo_valid", b_valid, 1'b0);
    chk("pd_lo_pready", b_pready, 1'b1);
    bus_idle();
    step();
    step();

    // timeout at the top address of the window, then a back-to-back ready read
    b_active = 2'b01; b_ready = 2'b00; b_value = {32'h0, 32'h0BAD_C0DE}; b_status = '0;
    setup_phase(1'b0, 8'h4F, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("to_valid", b_valid, 1'b1);
    chk("to_addr", b_addr, 4'hF);
    step();
    step();
    step();
    chk("to_t4_pready", b_pready, 1'b0);
    chk("to_t4_valid", b_valid, 1'b1);
    step();
    chk("to_t5_pready", b_pready, 1'b1);
    chk("to_pslverr", b_pslverr, 1'b1);
    chk("to_prdata", b_prdata, 32'hCAFE_F00D);
    chk("to_valid_fall", b_valid, 1'b0);
    b_ready = 2'b01;
    step();
    setup_phase(1'b0, 8'h48, 32'h0, 4'b0000);
    chk("b2b_t0_pready", b_pready, 1'b0);
    step();
    penable = 1'b1;
    chk("b2b_valid", b_valid, 1'b1);
    chk("b2b_addr", b_addr, 4'h8);
    step();
    chk("b2b_pready", b_pready, 1'b1);
    chk("b2b_prdata", b_prdata, 32'h0BAD_C0DE);
    chk("b2b_pslverr", b_pslverr, 1'b0);
    bus_idle(); b_active = '0; b_ready = '0;
    step();

    // abort by dropping psel during BUSY, then a normal transfer
    a_active = 2'b01; a_ready = 2'b00; a_value = {32'h0, 32'h1122_3344};
    setup_phase(1'b0, 8'h0C, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("ab_valid", a_valid, 1'b1);
    bus_idle();
    step();
    chk("ab_t2_valid", a_valid, 1'b0);
    chk("ab_t2_pready", a_pready, 1'b0);
    step();
    chk("ab_t3_pready", a_pready, 1'b0);
    a_ready = 2'b01;
    setup_phase(1'b0, 8'h0C, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("ab_re_valid", a_valid, 1'b1);
    step();
    chk("ab_re_pready", a_pready, 1'b1);
    chk("ab_re_prdata", a_prdata, 32'h1122_3344);
    bus_idle(); a_active = '0; a_ready = '0;
    step();

    // asynchronous reset in the middle of BUSY, then a normal transfer
    a_active = 2'b01; a_ready = 2'b00;
    setup_phase(1'b1, 8'h20, 32'hA1B2_C3D4, 4'b1111);
    step();
    penable = 1'b1;
    chk("rs_valid", a_valid, 1'b1);
    chk("rs_data", a_data, 32'hA1B2_C3D4);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rs_valid_clr", a_valid, 1'b0);
    chk("rs_write_clr", a_write, 1'b0);
    chk("rs_addr_clr", a_addr, 8'h00);
    chk("rs_data_clr", a_data, 32'h0);
    chk("rs_strobe_clr", a_strobe, 32'h0);
    chk("rs_pready_clr", a_pready, 1'b0);
    rst_n = 1'b1;
    bus_idle();
    step();
    chk("rs_after_pready", a_pready, 1'b0);
    a_ready = 2'b01; a_value = {32'h0, 32'h0F1E_2D3C};
    setup_phase(1'b0, 8'h24, 32'h0, 4'b0000);
    step();
    penable = 1'b1;
    chk("rs_re_addr", a_addr, 8'h24);
    step();
    chk("rs_re_pready", a_pready, 1'b1);
    chk("rs_re_prdata", a_prdata, 32'h0F1E_2D3C);
    chk("rs_re_pslverr", a_pslverr, 1'b0);
    bus_idle(); a_active = '0; a_ready = '0;
    step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
